axis_msg_depacketizer: RTL and testbench
========================================

Name: axis_msg_depacketizer

Overview:
- Receive end of the inter-node message protocol: consumes AXI-Stream messages of one 32-bit header word followed by the payload words, and strips and checks the header.
- Header format: [31:24] RX_UID (destination), [23:16] TX_UID (source), [15:0] payload length in bytes.
- Forwards payload addressed to this node to the local consumer with regenerated TLAST. Drops foreign or broadcast-excluded messages and flags length violations.
- Sits between the Aurora-side stream output and the matrix-multiplier input.

Parameters:
- UID_BROADCAST, 8'hFF, RX_UID value accepted by every node.
- LEN_W, 16, width of the header byte-length field; fixed header slice [15:0].
- CNT_W, 16, width of msg_count and word counters.

Ports:
- clk_200MHz  input  1  single clock; all logic on the rising edge.
- peripheral_aresetn  input  1  asynchronous active-low reset, released synchronously by the system.
- local_uid  input  8  this node's UID; sampled at each header beat.
- input_r_TDATA  input  32  inbound stream data.
- input_r_TLAST  input  1  inbound end of message.
- input_r_TVALID  input  1  inbound valid.
- input_r_TREADY  output  1  inbound ready.
- output_r_TDATA  output  32  payload data.
- output_r_TLAST  output  1  last payload beat.
- output_r_TVALID  output  1  payload valid.
- output_r_TREADY  input  1  downstream ready.
- src_uid  output  8  TX_UID of the last accepted header.
- msg_len  output  16  byte length of the last accepted header.
- msg_done  output  1  1-cycle pulse when a message finishes on the input side.
- err_dest  output  1  1-cycle pulse when a header is dropped for UID mismatch.
- err_len  output  1  1-cycle pulse on a TLAST/length disagreement.
- msg_count  output  CNT_W  count of delivered messages; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, peripheral_aresetn=0):
  - All outputs are 0. input_r_TREADY=0 while in reset and 1 in the first cycle after release.
  - FSM goes to HDR and the internal FIFO is cleared.
  - A reset mid-message discards the partial message with no pulses.
- Handshake: a beat transfers when VALID&READY. output_r_TVALID holds and data stays stable until accepted.
- Buffering: 2-entry output FIFO; input_r_TREADY = (fifo_count<2), registered.
  - Payload latency is 1 cycle from input beat to output_r_TVALID.
  - Full throughput when output_r_TREADY=1.
- words_exp = (len+3)>>2 (ceiling); the final beat may carry fewer than 4 valid bytes.
- FSM states: HDR, PAYLOAD, DROP.
- HDR, on a header beat:
  - Latch src_uid and msg_len; zero word_cnt.
  - Accept if RX_UID==local_uid or RX_UID==UID_BROADCAST. Otherwise pulse err_dest and go to DROP, or stay in HDR if TLAST=1.
  - Accepted with words_exp==0 and TLAST=1: pulse msg_done, increment msg_count, no output beat, stay in HDR.
  - Accepted with words_exp==0 and TLAST=0: pulse err_len, go to DROP.
  - Accepted with words_exp>0 and TLAST=1: pulse err_len, stay in HDR, no output.
  - Otherwise go to PAYLOAD.
- PAYLOAD: each beat is pushed to the FIFO and word_cnt is incremented.
  - The beat with word_cnt+1==words_exp and TLAST=1: push with TLAST=1, pulse msg_done, increment msg_count, go to HDR.
  - TLAST=1 early (count<words_exp): push with TLAST=1 (truncated message), pulse err_len and msg_done, increment msg_count, go to HDR.
  - Count reaches words_exp with TLAST=0: push with TLAST=1, pulse err_len, increment msg_count, go to DROP.
- DROP: accept and discard beats until a TLAST beat, then go to HDR.
  - input_r_TREADY=1 in DROP regardless of FIFO state.
  - No output beats and no pulses other than msg_done=0.
- Simultaneous pulses: err_len and msg_done may assert in the same cycle. err_dest never coincides with the others.
- output_r_TLAST is carried through the FIFO with its data beat.

Optional Feature:
- MSG_HDR_PASSTHRU_EN defined:
  - Accepted headers are also pushed to the FIFO as the first output beat (TLAST=0, or TLAST=1 for a zero-length message).
  - Latency and checks are unchanged.
- Undefined: headers are always stripped.

Test Plan:
- local_uid=8'h02; header 32'h02010360 then 216 beats of 32'h1, TLAST on the 216th -> 216 output beats of 32'h1, TLAST only on beat 216, src_uid=8'h01, msg_len=16'd864, one msg_done, msg_count=1, no errors.
- Same message with local_uid=8'h03 -> 217 input beats accepted, zero output beats, err_dest pulses once, msg_count unchanged. Then header 32'hFF010004 + 1 beat -> 1 output beat with TLAST.
- Header 32'h02010360 with TLAST on payload beat 100 -> 100 output beats, TLAST on beat 100, err_len and msg_done pulse together, FSM in HDR.
- Header 32'h02010360 with 220 payload beats, TLAST on beat 220 -> 216 output beats, TLAST on beat 216, err_len pulse, beats 217-220 dropped, next message is parsed correctly.
- Backpressure: output_r_TREADY low for 3 of every 8 cycles during the 216-beat message -> all 216 beats delivered in order, none duplicated, input_r_TREADY deasserts only while the FIFO holds 2.
- peripheral_aresetn pulsed low at payload beat 50 -> all outputs 0 immediately. After release, a fresh 32'h02010008 + 2 beats gives 2 output beats and msg_count=1.

Source files
------------

// File: rtl/axis_msg_depacketizer.sv
// axis_msg_depacketizer: strips and checks the 32-bit message header and forwards payload addressed to this node.
// Optional: define MSG_HDR_PASSTHRU_EN to also forward accepted headers as the first output beat.
module axis_msg_depacketizer #(
    parameter logic [7:0] UID_BROADCAST = 8'hFF,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_200MHz,
    input  logic             peripheral_aresetn,
    input  logic [7:0]       local_uid,
    input  logic [31:0]      input_r_TDATA,
    input  logic             input_r_TLAST,
    input  logic             input_r_TVALID,
    output logic             input_r_TREADY,
    output logic [31:0]      output_r_TDATA,
    output logic             output_r_TLAST,
    output logic             output_r_TVALID,
    input  logic             output_r_TREADY,
    output logic [7:0]       src_uid,
    output logic [LEN_W-1:0] msg_len,
    output logic             msg_done,
    output logic             err_dest,
    output logic             err_len,
    output logic [CNT_W-1:0] msg_count
);
    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt, words_exp, hdr_exp, cnt_inc;
    logic [32:0] mem [2];
    logic wp, rp;
    logic [1:0] fill, fill_nxt;
    logic beat, pop, push, push_last, hdr_ok, latch, done_nxt, elen_nxt, edest_nxt, inc;

    function automatic logic [CNT_W-1:0] words_of(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] s;
        s = {1'b0, len} + (LEN_W+1)'(3);
        return CNT_W'(s[LEN_W:2]);
    endfunction

    assign beat = input_r_TVALID & input_r_TREADY;
    assign pop = output_r_TVALID & output_r_TREADY;
    assign output_r_TVALID = fill != 2'd0;
    assign {output_r_TLAST, output_r_TDATA} = mem[rp];
    assign hdr_ok = input_r_TDATA[31:24] == local_uid || input_r_TDATA[31:24] == UID_BROADCAST;
    assign hdr_exp = words_of(input_r_TDATA[LEN_W-1:0]);
    assign words_exp = words_of(msg_len);
    assign cnt_inc = word_cnt + CNT_W'(1);
    assign fill_nxt = fill + {1'b0, push} - {1'b0, pop};

    // Next state, FIFO push and status pulse decode for the current input beat
    always_comb begin
        state_nxt = state;
        word_cnt_nxt = word_cnt;
        push = 1'b0;
        push_last = 1'b0;
        latch = 1'b0;
        done_nxt = 1'b0;
        elen_nxt = 1'b0;
        edest_nxt = 1'b0;
        inc = 1'b0;
        case (state)
            HDR: if (beat) begin
                latch = 1'b1;
                word_cnt_nxt = '0;
                if (!hdr_ok) begin
                    edest_nxt = 1'b1;
                    state_nxt = input_r_TLAST ? HDR : DROP;
                end else if (hdr_exp == '0) begin
                    done_nxt = input_r_TLAST;
                    inc = input_r_TLAST;
                    elen_nxt = !input_r_TLAST;
                    state_nxt = input_r_TLAST ? HDR : DROP;
                end else begin
                    elen_nxt = input_r_TLAST;
                    state_nxt = input_r_TLAST ? HDR : PAYLOAD;
                end
`ifdef MSG_HDR_PASSTHRU_EN
                push = hdr_ok;
                push_last = hdr_exp == '0 || input_r_TLAST;
`endif
            end
            PAYLOAD: if (beat) begin
                push = 1'b1;
                word_cnt_nxt = cnt_inc;
                if (input_r_TLAST || cnt_inc == words_exp) begin
                    push_last = 1'b1;
                    inc = 1'b1;
                    done_nxt = input_r_TLAST;
                    elen_nxt = !(input_r_TLAST && cnt_inc == words_exp);
                    state_nxt = input_r_TLAST ? HDR : DROP;
                end
            end
            DROP: if (beat && input_r_TLAST) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_200MHz or negedge peripheral_aresetn)
        if (!peripheral_aresetn) state <= HDR;
        else state <= state_nxt;

    // Header fields, word counter, status pulses and the registered input ready
    always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            word_cnt <= '0;
            src_uid <= '0;
            msg_len <= '0;
            msg_done <= 1'b0;
            err_len <= 1'b0;
            err_dest <= 1'b0;
            msg_count <= '0;
            input_r_TREADY <= 1'b0;
        end else begin
            word_cnt <= word_cnt_nxt;
            if (latch) begin
                src_uid <= input_r_TDATA[23:16];
                msg_len <= input_r_TDATA[LEN_W-1:0];
            end
            msg_done <= done_nxt;
            err_len <= elen_nxt;
            err_dest <= edest_nxt;
            if (inc) msg_count <= msg_count + CNT_W'(1);
            input_r_TREADY <= state_nxt == DROP || fill_nxt != 2'd2;
        end
    end

    // Two-entry output FIFO carrying TLAST alongside each data word
    always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            fill <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= {push_last, input_r_TDATA};
                wp <= !wp;
            end
            if (pop) rp <= !rp;
            fill <= fill_nxt;
        end
    end
endmodule

// File: tb/tb_axis_msg_depacketizer.sv
// tb_axis_msg_depacketizer: table vectors, corner sequences and randomized messages against a message-level model.
`timescale 1ns/1ps
module tb_axis_msg_depacketizer;
    logic clk_200MHz = 1'b0, peripheral_aresetn = 1'b0;
    logic [7:0] local_uid = 8'h02;
    logic [31:0] input_r_TDATA = '0;
    logic input_r_TLAST = 1'b0, input_r_TVALID = 1'b0, input_r_TREADY;
    logic [31:0] output_r_TDATA;
    logic output_r_TLAST, output_r_TVALID, output_r_TREADY = 1'b1;
    logic [7:0] src_uid;
    logic [15:0] msg_len, msg_count;
    logic msg_done, err_dest, err_len;

    axis_msg_depacketizer dut (
        .clk_200MHz(clk_200MHz), .peripheral_aresetn(peripheral_aresetn), .local_uid(local_uid),
        .input_r_TDATA(input_r_TDATA), .input_r_TLAST(input_r_TLAST), .input_r_TVALID(input_r_TVALID),
        .input_r_TREADY(input_r_TREADY), .output_r_TDATA(output_r_TDATA), .output_r_TLAST(output_r_TLAST),
        .output_r_TVALID(output_r_TVALID), .output_r_TREADY(output_r_TREADY), .src_uid(src_uid),
        .msg_len(msg_len), .msg_done(msg_done), .err_dest(err_dest), .err_len(err_len), .msg_count(msg_count)
    );

    always #5 clk_200MHz = ~clk_200MHz;

    typedef struct {
        logic [7:0] uid; logic [31:0] hdr; int n; int rm;
        int outs; int done; int elen; int edest; int inc;
    } vec_t;
    vec_t tbl[12];
    logic [32:0] in_q[$], out_q[$], exp_q[$];
    int checks = 0, errors = 0;
    int n_done, n_elen, n_edest, n_clash, n_in, rdy_low, rdy_bad, cyc = 0;
    int m_done, m_elen, m_edest, exp_count = 0;
    int vprob = 100, rmode = 0;
    logic in_fire, out_fire;
    logic [31:0] last_hdr;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] pay(input int tag, input int i);
        return 32'h5A00_0000 ^ (32'(tag) << 16) ^ 32'(i);
    endfunction

    task automatic clr();
        out_q.delete();
        n_done = 0; n_elen = 0; n_edest = 0; n_clash = 0; n_in = 0; rdy_low = 0; rdy_bad = 0;
    endtask

    task automatic step();
        @(negedge clk_200MHz);
        in_fire = input_r_TVALID && input_r_TREADY;
        out_fire = output_r_TVALID && output_r_TREADY;
        if (out_fire) out_q.push_back({output_r_TLAST, output_r_TDATA});
        if (in_fire) n_in++;
        n_done += int'(msg_done);
        n_elen += int'(err_len);
        n_edest += int'(err_dest);
        if (err_dest && (msg_done || err_len)) n_clash++;
        if (peripheral_aresetn && !input_r_TREADY) begin
            rdy_low++;
            if (!output_r_TVALID) rdy_bad++;
        end
        @(posedge clk_200MHz);
        #1;
        cyc++;
        if (in_fire) void'(in_q.pop_front());
        if (in_fire || !input_r_TVALID) input_r_TVALID = in_q.size() > 0 && int'($urandom_range(99)) < vprob;
        {input_r_TLAST, input_r_TDATA} = in_q.size() > 0 ? in_q[0] : 33'h0;
        output_r_TREADY = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 8 >= 3) : ($urandom_range(3) != 0);
    endtask

    task automatic run_until_idle();
        int b = 0;
        while ((in_q.size() > 0 || input_r_TVALID) && b < 20000) begin
            step();
            b++;
        end
        check("input drained before timeout", longint'(b < 20000), 1);
        repeat (12) step();
    endtask

    task automatic send_msg(input logic [31:0] hdr, input int n, input int tag);
        in_q.push_back({n == 0, hdr});
        for (int i = 0; i < n; i++) in_q.push_back({i == n - 1, pay(tag, i)});
        last_hdr = hdr;
    endtask

    // Message-level reference: what each whole message should produce
    task automatic model_msg(input logic [31:0] hdr, input int n, input int tag);
        int wexp = (int'(hdr[15:0]) + 3) / 4;
        int k;
        if (hdr[31:24] != local_uid && hdr[31:24] != 8'hFF) m_edest++;
        else if (wexp == 0) begin
            if (n == 0) begin m_done++; exp_count++; end
            else m_elen++;
        end else if (n == 0) m_elen++;
        else begin
            k = n < wexp ? n : wexp;
            for (int i = 0; i < k; i++) exp_q.push_back({i == k - 1, pay(tag, i)});
            exp_count++;
            if (n <= wexp) m_done++;
            if (n != wexp) m_elen++;
        end
    endtask

    task automatic cmp_beats(input string name);
        int bad = 0;
        check({name, " beat count"}, out_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i < out_q.size() && out_q[i] !== exp_q[i]) bad++;
        check({name, " wrong beats"}, bad, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " TREADY"}, input_r_TREADY, 0);
        check({tag, " TVALID"}, output_r_TVALID, 0);
        check({tag, " TDATA"}, output_r_TDATA, 0);
        check({tag, " TLAST"}, output_r_TLAST, 0);
        check({tag, " src_uid"}, src_uid, 0);
        check({tag, " msg_len"}, msg_len, 0);
        check({tag, " pulses"}, {msg_done, err_dest, err_len}, 0);
        check({tag, " msg_count"}, msg_count, 0);
    endtask

    task automatic release_reset();
        @(posedge clk_200MHz);
        #1;
        peripheral_aresetn = 1'b1;
        @(posedge clk_200MHz);
        #1;
        check("TREADY first cycle after reset", input_r_TREADY, 1);
    endtask

    initial begin
        tbl[0]  = '{8'h02, 32'h02010360, 216, 0, 216, 1, 0, 0, 1};
        tbl[1]  = '{8'h03, 32'h02010360, 216, 0,   0, 0, 0, 1, 0};
        tbl[2]  = '{8'h03, 32'hFF010004,   1, 0,   1, 1, 0, 0, 1};
        tbl[3]  = '{8'h02, 32'h02010360, 100, 0, 100, 1, 1, 0, 1};
        tbl[4]  = '{8'h02, 32'h02010360, 220, 0, 216, 0, 1, 0, 1};
        tbl[5]  = '{8'h02, 32'h02010008,   2, 0,   2, 1, 0, 0, 1};
        tbl[6]  = '{8'h02, 32'h02010360, 216, 1, 216, 1, 0, 0, 1};
        tbl[7]  = '{8'h02, 32'h02050000,   0, 0,   0, 1, 0, 0, 1};
        tbl[8]  = '{8'h02, 32'h02050000,   3, 0,   0, 0, 1, 0, 0};
        tbl[9]  = '{8'h02, 32'h02050005,   0, 0,   0, 0, 1, 0, 0};
        tbl[10] = '{8'h02, 32'h07010004,   0, 0,   0, 0, 0, 1, 0};
        tbl[11] = '{8'h02, 32'h02010007,   2, 2,   2, 1, 0, 0, 1};
        #1;
        check_zero_outputs("reset");
        release_reset();

        for (int r = 0; r < 12; r++) begin
            clr();
            exp_q.delete();
            local_uid = tbl[r].uid;
            rmode = tbl[r].rm;
            send_msg(tbl[r].hdr, tbl[r].n, r);
            for (int i = 0; i < tbl[r].outs; i++) exp_q.push_back({i == tbl[r].outs - 1, pay(r, i)});
            exp_count += tbl[r].inc;
            run_until_idle();
            cmp_beats($sformatf("vec%0d", r));
            check($sformatf("vec%0d input beats", r), n_in, tbl[r].n + 1);
            check($sformatf("vec%0d msg_done", r), n_done, tbl[r].done);
            check($sformatf("vec%0d err_len", r), n_elen, tbl[r].elen);
            check($sformatf("vec%0d err_dest", r), n_edest, tbl[r].edest);
            check($sformatf("vec%0d pulse clash", r), n_clash, 0);
            check($sformatf("vec%0d msg_count", r), msg_count, exp_count);
            check($sformatf("vec%0d src_uid", r), src_uid, tbl[r].hdr[23:16]);
            check($sformatf("vec%0d msg_len", r), msg_len, tbl[r].hdr[15:0]);
            check($sformatf("vec%0d ready low with FIFO not full", r), rdy_bad, 0);
            if (tbl[r].rm == 0) check($sformatf("vec%0d ready low cycles", r), rdy_low, 0);
            if (tbl[r].rm == 1) check($sformatf("vec%0d ready dropped under backpressure", r), longint'(rdy_low > 0), 1);
        end

        // reset in the middle of a payload
        clr();
        rmode = 0;
        local_uid = 8'h02;
        send_msg(32'h02010360, 216, 50);
        for (int b = 0; n_in < 51 && b < 2000; b++) step();
        check("mid-reset beats accepted", n_in, 51);
        peripheral_aresetn = 1'b0;
        #1;
        check_zero_outputs("mid-reset");
        in_q.delete();
        input_r_TVALID = 1'b0;
        release_reset();
        exp_count = 0;
        clr();
        exp_q.delete();
        send_msg(32'h02010008, 2, 51);
        for (int i = 0; i < 2; i++) exp_q.push_back({i == 1, pay(51, i)});
        run_until_idle();
        cmp_beats("after reset");
        check("after reset msg_count", msg_count, 1);
        check("after reset msg_done", n_done, 1);
        check("after reset err_len", n_elen, 0);
        exp_count = 1;

        // randomized messages with random valid gaps and random output ready
        clr();
        exp_q.delete();
        m_done = 0; m_elen = 0; m_edest = 0;
        vprob = 70;
        rmode = 2;
        for (int m = 0; m < 40; m++) begin
            int sel = int'($urandom_range(3));
            int len = int'($urandom_range(40));
            int n = int'($urandom_range(4)) - 2 + (len + 3) / 4;
            logic [7:0] rx;
            rx = sel < 2 ? 8'h02 : sel == 2 ? 8'hFF : 8'(16 + $urandom_range(200));
            if (n < 0 || $urandom_range(5) == 0) n = 0;
            send_msg({rx, 8'(m), 16'(len)}, n, 100 + m);
            model_msg({rx, 8'(m), 16'(len)}, n, 100 + m);
        end
        run_until_idle();
        cmp_beats("random");
        check("random msg_done", n_done, m_done);
        check("random err_len", n_elen, m_elen);
        check("random err_dest", n_edest, m_edest);
        check("random pulse clash", n_clash, 0);
        check("random msg_count", msg_count, exp_count);
        check("random ready low with FIFO not full", rdy_bad, 0);
        check("random src_uid", src_uid, last_hdr[23:16]);
        check("random msg_len", msg_len, last_hdr[15:0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
